// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI burst register-bank slave.
package spi_slave_pkg;

  // Transaction phases of the slave.
  typedef enum logic [2:0] {
    HDR   = 3'd0,
    TURN  = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Header field positions, counted in transmission order (bit 0 is sent first).
  localparam int RW_BIT   = 0;
  localparam int INC_BIT  = 1;
  localparam int ADDR_LSB = 2;

  // RW field value that selects a read transaction.
  localparam logic RW_READ = 1'b1;

  // Larger of two integers; used to size counters at elaboration time.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_tx_shift.sv
// Negedge MISO shifter: loads a prefetched word and shifts it out MSB first.
module spi_tx_shift #(
  parameter int DWIDTH = 16
) (
  input  logic              spi_clk,
  input  logic              reset,
  input  logic              load,
  input  logic              shift,
  input  logic [DWIDTH-1:0] load_data,
  output logic              miso
);

  logic [DWIDTH-1:0] sr;

  // Load a new word, shift the current one, or idle at zero so MISO is 0 outside READ.
  always_ff @(negedge spi_clk or posedge reset) begin
    if (reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= load_data;
    end else if (shift) begin
      sr <= {sr[DWIDTH-2:0], 1'b0};
    end else begin
      sr <= '0;
    end
  end

  assign miso = sr[DWIDTH-1];

endmodule

// File: rtl/spi_burst_slave.sv
// SPI register-bank slave: decodes a header, then streams write words into
// one-cycle write strobes or serialises prefetched read words onto MISO.
//
// Strobe protocol: wr_req and rd_req are single-cycle pulses with no back
// pressure. wr_addr/wr_data (or rd_addr) are valid exactly while the pulse
// is high and hold their last value afterwards. For reads, the bank must
// present rd_data by the next negedge after rd_req and keep it stable until
// the shifter loads it at the negedge before that word's first data bit.
module spi_burst_slave
  import spi_slave_pkg::*;
#(
  parameter int DWIDTH     = 16,
  parameter int AWIDTH     = 7,
  parameter int TURNAROUND = 0,
  parameter int MAX_WORDS  = 2**AWIDTH
) (
  input  logic                           spi_clk,
  input  logic                           reset,
  input  logic                           spi_mosi,
  output logic                           spi_miso,
  output logic                           wr_req,
  output logic [AWIDTH-1:0]              wr_addr,
  output logic [DWIDTH-1:0]              wr_data,
  output logic                           rd_req,
  output logic [AWIDTH-1:0]              rd_addr,
  input  logic [DWIDTH-1:0]              rd_data,
  output logic                           busy,
  output logic [$clog2(MAX_WORDS+1)-1:0] word_cnt,
  output state_t                         state_dbg
);

  localparam int H       = AWIDTH + 2;
  localparam int RXW     = max_int(DWIDTH, H);
  localparam int CNT_TOP = max_int(max_int(H, DWIDTH), TURNAROUND);
  localparam int CW      = $clog2(CNT_TOP + 1);
  localparam int WCW     = $clog2(MAX_WORDS + 1);

  state_t            state, state_n;
  logic [CW-1:0]     bit_cnt, bit_cnt_n;
  logic [RXW-2:0]    rx_sr, rx_n;
  logic [RXW-1:0]    rx_in;
  logic [H-1:0]      hdr;
  logic [AWIDTH-1:0] hdr_addr;
  logic              hdr_rw, hdr_inc;
  logic [AWIDTH-1:0] addr, addr_n, addr_next;
  logic              inc, inc_n;
  logic [WCW-1:0]    word_cnt_n;
  logic              last_word;
  logic              wr_req_n, rd_req_n, busy_n;
  logic [AWIDTH-1:0] wr_addr_n, rd_addr_n;
  logic [DWIDTH-1:0] wr_data_n;
  logic              tx_load, tx_shift;

  // Incoming bits including the one being sampled on this edge.
  assign rx_in    = {rx_sr, spi_mosi};
  assign hdr      = rx_in[H-1:0];
  assign hdr_rw   = hdr[H-1-RW_BIT];
  assign hdr_inc  = hdr[H-1-INC_BIT];
  assign hdr_addr = hdr[H-1-ADDR_LSB -: AWIDTH];

  // Address of the following word: wraps when incrementing, fixed for FIFO ports.
  assign addr_next = inc ? addr + AWIDTH'(1) : addr;
  assign last_word = (word_cnt == WCW'(MAX_WORDS - 1));

  // Next-state, counters and strobes for every phase of the transaction.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt + CW'(1);
    rx_n       = rx_in[RXW-2:0];
    addr_n     = addr;
    inc_n      = inc;
    word_cnt_n = word_cnt;
    wr_req_n   = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    rd_req_n   = 1'b0;
    rd_addr_n  = rd_addr;
    case (state)
      HDR: begin
        if (bit_cnt == CW'(H - 1)) begin
          bit_cnt_n = '0;
          addr_n    = hdr_addr;
          inc_n     = hdr_inc;
          if (hdr_rw == RW_READ) begin
            rd_req_n  = 1'b1;
            rd_addr_n = hdr_addr;
            state_n   = (TURNAROUND > 0) ? TURN : READ;
          end else begin
            state_n = WRITE;
          end
        end
      end
      TURN: begin
        if (bit_cnt == CW'(TURNAROUND - 1)) begin
          bit_cnt_n = '0;
          state_n   = READ;
        end
      end
      WRITE: begin
        if (bit_cnt == CW'(DWIDTH - 1)) begin
          wr_req_n   = 1'b1;
          wr_addr_n  = addr;
          wr_data_n  = rx_in[DWIDTH-1:0];
          bit_cnt_n  = '0;
          word_cnt_n = word_cnt + WCW'(1);
          addr_n     = addr_next;
          if (last_word) state_n = DONE;
        end
      end
      READ: begin
        // Mid-word prefetch of the next word, skipped once no further word is allowed.
        if (bit_cnt == CW'(DWIDTH/2 - 1) && !last_word) begin
          rd_req_n  = 1'b1;
          rd_addr_n = addr_next;
        end
        if (bit_cnt == CW'(DWIDTH - 1)) begin
          bit_cnt_n  = '0;
          word_cnt_n = word_cnt + WCW'(1);
          addr_n     = addr_next;
          if (last_word) state_n = DONE;
        end
      end
      DONE: begin
        bit_cnt_n = bit_cnt;
      end
      default: begin
        state_n = HDR;
      end
    endcase
    busy_n = (state_n != HDR);
  end

  // State register and all posedge-registered outputs.
  always_ff @(posedge spi_clk or posedge reset) begin
    if (reset) begin
      state    <= HDR;
      bit_cnt  <= '0;
      rx_sr    <= '0;
      addr     <= '0;
      inc      <= 1'b0;
      word_cnt <= '0;
      wr_req   <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rd_req   <= 1'b0;
      rd_addr  <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      rx_sr    <= rx_n;
      addr     <= addr_n;
      inc      <= inc_n;
      word_cnt <= word_cnt_n;
      wr_req   <= wr_req_n;
      wr_addr  <= wr_addr_n;
      wr_data  <= wr_data_n;
      rd_req   <= rd_req_n;
      rd_addr  <= rd_addr_n;
      busy     <= busy_n;
    end
  end

  // Load at the start of each read word, shift through the rest of it.
  assign tx_load  = (state == READ) && (bit_cnt == '0);
  assign tx_shift = (state == READ);

  spi_tx_shift #(.DWIDTH(DWIDTH)) u_tx (
    .spi_clk   (spi_clk),
    .reset     (reset),
    .load      (tx_load),
    .shift     (tx_shift),
    .load_data (rd_data),
    .miso      (spi_miso)
  );

  assign state_dbg = state;

endmodule

// File: tb/tb_spi_burst_slave.sv
// Bench for spi_burst_slave: two instances (TURNAROUND 0 and 4) share one SPI
// master stream; each frame is scored against a transaction-level model.
module tb_spi_burst_slave;
  import spi_slave_pkg::*;

  localparam int DW  = 16;
  localparam int AW  = 7;
  localparam int MW  = 4;
  localparam int H   = AW + 2;
  localparam int T1  = 4;
  localparam int WCW = $clog2(MW + 1);

  // ---------------- clock / reset ----------------
  logic spi_clk  = 1'b0;
  logic rst      = 1'b1;
  logic cs_n     = 1'b1;
  logic spi_mosi = 1'b0;
  logic reset;
  assign reset = rst | cs_n;
  always #5 spi_clk = ~spi_clk;

  logic           miso0, wr_req0, rd_req0, busy0;
  logic [AW-1:0]  wr_addr0, rd_addr0;
  logic [DW-1:0]  wr_data0;
  logic [DW-1:0]  rd_data0 = '0;
  logic [WCW-1:0] word_cnt0;
  state_t         st0;

  logic           miso1, wr_req1, rd_req1, busy1;
  logic [AW-1:0]  wr_addr1, rd_addr1;
  logic [DW-1:0]  wr_data1;
  logic [DW-1:0]  rd_data1 = '0;
  logic [WCW-1:0] word_cnt1;
  state_t         st1;

  spi_burst_slave #(.DWIDTH(DW), .AWIDTH(AW), .TURNAROUND(0), .MAX_WORDS(MW)) dut0 (
    .spi_clk(spi_clk), .reset(reset), .spi_mosi(spi_mosi), .spi_miso(miso0),
    .wr_req(wr_req0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .rd_req(rd_req0), .rd_addr(rd_addr0), .rd_data(rd_data0),
    .busy(busy0), .word_cnt(word_cnt0), .state_dbg(st0)
  );

  spi_burst_slave #(.DWIDTH(DW), .AWIDTH(AW), .TURNAROUND(T1), .MAX_WORDS(MW)) dut1 (
    .spi_clk(spi_clk), .reset(reset), .spi_mosi(spi_mosi), .spi_miso(miso1),
    .wr_req(wr_req1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .rd_req(rd_req1), .rd_addr(rd_addr1), .rd_data(rd_data1),
    .busy(busy1), .word_cnt(word_cnt1), .state_dbg(st1)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Register bank: answers a prefetch shortly after rd_req rises.
  logic [DW-1:0] bank [0:(1<<AW)-1];
  always @(posedge spi_clk) begin
    #1;
    if (rd_req0) rd_data0 = bank[rd_addr0];
    if (rd_req1) rd_data1 = bank[rd_addr1];
  end

  // Strobe monitors, sampled mid-cycle.
  logic [AW+DW-1:0] got_wr0[$], got_wr1[$];
  logic [AW-1:0]    got_rd0[$], got_rd1[$];
  int clash0, clash1;
  always @(negedge spi_clk) begin
    if (wr_req0) got_wr0.push_back({wr_addr0, wr_data0});
    if (rd_req0) got_rd0.push_back(rd_addr0);
    if (wr_req0 && rd_req0) clash0++;
    if (wr_req1) got_wr1.push_back({wr_addr1, wr_data1});
    if (rd_req1) got_rd1.push_back(rd_addr1);
    if (wr_req1 && rd_req1) clash1++;
  end

  // ---------------- driver ----------------
  logic           mosi_bits[$];
  logic [DW-1:0]  words_q[$];
  logic [255:0]   miso_v0, miso_v1;
  logic [WCW-1:0] end_wc0, end_wc1;
  logic           end_busy0, end_busy1;
  state_t         end_st0, end_st1;

  task automatic build_bits(input logic rw, input logic inc, input logic [AW-1:0] a, input int nbits);
    logic [H-1:0] hdr;
    hdr = {rw, inc, a};
    mosi_bits.delete();
    for (int i = 0; i < nbits; i++) begin
      if (i < H) begin
        mosi_bits.push_back(hdr[H-1-i]);
      end else if (!rw && ((i - H) / DW) < words_q.size()) begin
        logic [DW-1:0] w;
        w = words_q[(i - H) / DW];
        mosi_bits.push_back(w[DW-1-((i - H) % DW)]);
      end else begin
        mosi_bits.push_back(1'($urandom_range(0, 1)));
      end
    end
  endtask

  // One chip-select window: drive MOSI and capture MISO for every bit slot.
  task automatic run_frame();
    miso_v0 = '0;
    miso_v1 = '0;
    got_wr0.delete(); got_wr1.delete(); got_rd0.delete(); got_rd1.delete();
    clash0 = 0;
    clash1 = 0;
    @(negedge spi_clk);
    #1 cs_n = 1'b0;
    for (int i = 0; i < mosi_bits.size(); i++) begin
      if (i > 0) @(negedge spi_clk);
      #2;
      miso_v0[i] = miso0;
      miso_v1[i] = miso1;
      spi_mosi   = mosi_bits[i];
    end
    @(negedge spi_clk);
    #2;
    end_wc0 = word_cnt0; end_busy0 = busy0; end_st0 = st0;
    end_wc1 = word_cnt1; end_busy1 = busy1; end_st1 = st1;
    cs_n = 1'b1;
    #1;
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [AW+DW-1:0] exp_wr_q[$];
  logic [AW-1:0]    exp_rd_q[$];

  function automatic logic [AW-1:0] word_addr(input logic inc, input logic [AW-1:0] a0, input int k);
    return inc ? AW'(int'(a0) + k) : a0;
  endfunction

  task automatic score_frame(input int d, input string tag, input logic rw, input logic inc,
                             input logic [AW-1:0] a0, input int nbits);
    int turn, data_bits, exp_wc, slot, got_clash;
    logic exp_busy, got_busy;
    logic [255:0] exp_miso, got_miso;
    logic [AW+DW-1:0] gw[$];
    logic [AW-1:0] gr[$];
    logic [WCW-1:0] got_wc;
    logic [DW-1:0] bw;
    turn = (d == 0) ? 0 : T1;
    exp_wr_q.delete();
    exp_rd_q.delete();
    exp_miso = '0;
    exp_wc   = 0;
    exp_busy = 1'b0;
    if (nbits >= H) begin
      exp_busy  = 1'b1;
      data_bits = nbits - H - (rw ? turn : 0);
      if (data_bits < 0) data_bits = 0;
      exp_wc = data_bits / DW;
      if (exp_wc > MW) exp_wc = MW;
      if (!rw) begin
        for (int k = 0; k < exp_wc; k++) exp_wr_q.push_back({word_addr(inc, a0, k), words_q[k]});
      end else begin
        exp_rd_q.push_back(a0);
        for (int k = 0; k < MW - 1; k++)
          if (data_bits >= k * DW + DW / 2) exp_rd_q.push_back(word_addr(inc, a0, k + 1));
        for (int k = 0; k < MW; k++) begin
          bw = bank[word_addr(inc, a0, k)];
          for (int j = 0; j < DW; j++) begin
            slot = H + turn + k * DW + j;
            if (slot < nbits) exp_miso[slot] = bw[DW-1-j];
          end
        end
      end
    end
    if (d == 0) begin
      gw = got_wr0; gr = got_rd0; got_miso = miso_v0; got_wc = end_wc0; got_busy = end_busy0; got_clash = clash0;
    end else begin
      gw = got_wr1; gr = got_rd1; got_miso = miso_v1; got_wc = end_wc1; got_busy = end_busy1; got_clash = clash1;
    end
    tests_run++;
    if (gw.size() != exp_wr_q.size()) begin
      tests_failed++;
      $display("FAIL %s dut%0d wr_count: got %0d expected %0d", tag, d, gw.size(), exp_wr_q.size());
    end else begin
      for (int i = 0; i < gw.size(); i++) begin
        tests_run++;
        if (gw[i] !== exp_wr_q[i]) begin
          tests_failed++;
          $display("FAIL %s dut%0d wr[%0d] addr_data: got %h expected %h", tag, d, i, gw[i], exp_wr_q[i]);
        end
      end
    end
    tests_run++;
    if (gr.size() != exp_rd_q.size()) begin
      tests_failed++;
      $display("FAIL %s dut%0d rd_count: got %0d expected %0d", tag, d, gr.size(), exp_rd_q.size());
    end else begin
      for (int i = 0; i < gr.size(); i++) begin
        tests_run++;
        if (gr[i] !== exp_rd_q[i]) begin
          tests_failed++;
          $display("FAIL %s dut%0d rd[%0d] addr: got %h expected %h", tag, d, i, gr[i], exp_rd_q[i]);
        end
      end
    end
    tests_run++;
    if (got_miso !== exp_miso) begin
      tests_failed++;
      $display("FAIL %s dut%0d miso_slots: got %h expected %h", tag, d, got_miso, exp_miso);
    end
    tests_run++;
    if (got_wc !== WCW'(exp_wc)) begin
      tests_failed++;
      $display("FAIL %s dut%0d word_cnt: got %0d expected %0d", tag, d, got_wc, exp_wc);
    end
    tests_run++;
    if (got_busy !== exp_busy) begin
      tests_failed++;
      $display("FAIL %s dut%0d busy: got %b expected %b", tag, d, got_busy, exp_busy);
    end
    tests_run++;
    if (got_clash != 0) begin
      tests_failed++;
      $display("FAIL %s dut%0d strobe_overlap: got %0d expected 0", tag, d, got_clash);
    end
  endtask

  task automatic do_frame(input string tag, input logic rw, input logic inc, input logic [AW-1:0] a, input int nbits);
    build_bits(rw, inc, a, nbits);
    run_frame();
    score_frame(0, tag, rw, inc, a, nbits);
    score_frame(1, tag, rw, inc, a, nbits);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (3) @(negedge spi_clk);
    #2;
    tests_run++; if (miso0 !== 1'b0)    begin tests_failed++; $display("FAIL reset miso: got %b expected 0", miso0); end
    tests_run++; if (wr_req0 !== 1'b0)  begin tests_failed++; $display("FAIL reset wr_req: got %b expected 0", wr_req0); end
    tests_run++; if (rd_req0 !== 1'b0)  begin tests_failed++; $display("FAIL reset rd_req: got %b expected 0", rd_req0); end
    tests_run++; if (wr_addr0 !== '0)   begin tests_failed++; $display("FAIL reset wr_addr: got %h expected 0", wr_addr0); end
    tests_run++; if (wr_data0 !== '0)   begin tests_failed++; $display("FAIL reset wr_data: got %h expected 0", wr_data0); end
    tests_run++; if (rd_addr0 !== '0)   begin tests_failed++; $display("FAIL reset rd_addr: got %h expected 0", rd_addr0); end
    tests_run++; if (busy0 !== 1'b0)    begin tests_failed++; $display("FAIL reset busy: got %b expected 0", busy0); end
    tests_run++; if (word_cnt0 !== '0)  begin tests_failed++; $display("FAIL reset word_cnt: got %0d expected 0", word_cnt0); end
    tests_run++; if (st0 !== HDR)       begin tests_failed++; $display("FAIL reset state: got %0d expected %0d", st0, HDR); end
    tests_run++;
    if ({miso1, wr_req1, rd_req1, wr_addr1, wr_data1, rd_addr1, busy1, word_cnt1} !== '0 || st1 !== HDR) begin
      tests_failed++;
      $display("FAIL reset dut1_outputs: got nonzero expected all zero");
    end
    rst = 1'b0;
  endtask

  task automatic test_write_inc();
    words_q = '{16'hA5A5, 16'h1234};
    do_frame("write_inc", 1'b0, 1'b1, 7'h10, H + 2 * DW);
    tests_run++;
    if (got_wr0.size() != 2 || got_wr0[0] !== {7'h10, 16'hA5A5} || got_wr0[1] !== {7'h11, 16'h1234}) begin
      tests_failed++;
      $display("FAIL write_inc strobes: got %0d strobes expected (10,a5a5),(11,1234)", got_wr0.size());
    end
    tests_run++;
    if (end_wc0 !== WCW'(2)) begin tests_failed++; $display("FAIL write_inc word_cnt: got %0d expected 2", end_wc0); end
  endtask

  task automatic test_read_wrap();
    logic [DW-1:0] w;
    logic [DW-1:0] want [3];
    want = '{16'hFF80, 16'hFFFF, 16'hFFFE};
    for (int a = 0; a < (1 << AW); a++) bank[a] = DW'(a) ^ 16'hFFFF;
    words_q.delete();
    do_frame("read_wrap", 1'b1, 1'b1, 7'h7F, H + 3 * DW);
    tests_run++;
    if (got_rd0.size() < 3 || got_rd0[0] !== 7'h7F || got_rd0[1] !== 7'h00 || got_rd0[2] !== 7'h01) begin
      tests_failed++;
      $display("FAIL read_wrap rd_addr_seq: got %0d strobes expected 7f,00,01 first", got_rd0.size());
    end
    for (int k = 0; k < 3; k++) begin
      w = '0;
      for (int j = 0; j < DW; j++) w = {w[DW-2:0], miso_v0[H + k * DW + j]};
      tests_run++;
      if (w !== want[k]) begin
        tests_failed++;
        $display("FAIL read_wrap miso_word%0d: got %h expected %h", k, w, want[k]);
      end
    end
  endtask

  task automatic test_write_fixed();
    words_q.delete();
    for (int k = 0; k < 5; k++) words_q.push_back(DW'($urandom));
    do_frame("write_fixed", 1'b0, 1'b0, 7'h05, H + 5 * DW);
    tests_run++;
    if (end_st0 !== DONE) begin tests_failed++; $display("FAIL write_fixed state: got %0d expected %0d", end_st0, DONE); end
    tests_run++;
    if (end_busy0 !== 1'b1) begin tests_failed++; $display("FAIL write_fixed busy: got %b expected 1", end_busy0); end
  endtask

  task automatic test_turnaround();
    logic [DW-1:0] w;
    for (int a = 0; a < (1 << AW); a++) bank[a] = DW'($urandom);
    words_q.delete();
    do_frame("turnaround", 1'b1, 1'b1, 7'h02, H + T1 + 2 * DW);
    w = '0;
    for (int j = 0; j < DW; j++) w = {w[DW-2:0], miso_v1[H + T1 + j]};
    tests_run++;
    if (w !== bank[2]) begin tests_failed++; $display("FAIL turnaround first_word: got %h expected %h", w, bank[2]); end
  endtask

  task automatic test_cs_abort();
    words_q = '{16'hBEEF};
    do_frame("cs_abort", 1'b0, 1'b1, 7'h21, H + 9);
    tests_run++;
    if ({miso0, wr_req0, rd_req0, wr_addr0, wr_data0, rd_addr0, busy0, word_cnt0} !== '0 || st0 !== HDR) begin
      tests_failed++;
      $display("FAIL cs_abort dut0_idle: got busy=%b wc=%0d st=%0d expected all zero", busy0, word_cnt0, st0);
    end
    tests_run++;
    if ({miso1, wr_req1, rd_req1, wr_addr1, wr_data1, rd_addr1, busy1, word_cnt1} !== '0 || st1 !== HDR) begin
      tests_failed++;
      $display("FAIL cs_abort dut1_idle: got busy=%b wc=%0d st=%0d expected all zero", busy1, word_cnt1, st1);
    end
    words_q = '{16'h0F0F};
    do_frame("after_abort", 1'b0, 1'b1, 7'h33, H + DW);
  endtask

  task automatic test_short_header();
    words_q.delete();
    do_frame("short_hdr", 1'b1, 1'b1, 7'h44, 5);
    tests_run++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL short_hdr busy_after_cs: got %b%b expected 00", busy0, busy1);
    end
  endtask

  task automatic test_random();
    logic rw, inc;
    logic [AW-1:0] a;
    int nbits;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < (1 << AW); i++) bank[i] = DW'($urandom);
      words_q.delete();
      for (int k = 0; k < 8; k++) words_q.push_back(DW'($urandom));
      rw    = 1'($urandom_range(0, 1));
      inc   = 1'($urandom_range(0, 1));
      a     = AW'($urandom);
      nbits = $urandom_range(1, H + T1 + 6 * DW);
      do_frame("random", rw, inc, a, nbits);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_write_inc();
    test_read_wrap();
    test_write_fixed();
    test_turnaround();
    test_cs_abort();
    test_short_header();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
